// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and default constants for the uart transmit arbiter.
//   arb_state_t : arbiter FSM state encoding (IDLE, START, WAIT_DONE)
//   NREQ_DEF    : default number of requesters
//   DBIT_DEF    : default data bits per character
//   TO_W_DEF    : default watchdog counter width
package uart_arb_pkg;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned DBIT_DEF = 8;
  localparam int unsigned TO_W_DEF = 20;

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE} arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
// Scans the valid vector from rr_ptr upward (modulo NREQ) and returns the first hit.
// Ports:
//   valid      in  NREQ  request vector
//   rr_ptr     in  IDW   highest-priority index for this scan
//   winner_oh  out NREQ  one-hot winner (zero when nothing is valid)
//   winner_idx out IDW   winner index (zero when nothing is valid)
//   any_valid  out 1     at least one request is valid
module rr_pick #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] winner_oh,
  output logic [IDW-1:0]  winner_idx,
  output logic            any_valid
);

  logic           found;
  int unsigned    pos;
  logic [IDW-1:0] pos_idx;

  assign any_valid = |valid;

  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    found      = 1'b0;
    pos        = 0;
    pos_idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = 32'(rr_ptr) + k;
      if (pos >= NREQ) begin
        pos = pos - NREQ;
      end
      pos_idx = IDW'(pos);
      if (!found && valid[pos_idx]) begin
        found              = 1'b1;
        winner_oh[pos_idx] = 1'b1;
        winner_idx         = pos_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one uart transmitter among NREQ requesters.
// A byte is taken on req_valid && req_ready, presented on uart_din with a one-cycle
// uart_tx_start, and the owner gets a one-cycle req_done once uart_tx_done_tick arrives.
// A watchdog returns the arbiter to IDLE (pulsing timeout_err) if the done tick never comes.
// Optional build macro UART_LOOPBACK_CHECK_EN adds rx_done_tick/rx_dout/lb_err: completion
// then also waits for the looped-back rx byte and lb_err latches any data mismatch.
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_data/req_ready/req_done : requester side (NREQ lanes, DBIT bytes)
//   uart_din/uart_tx_start/uart_tx_busy/uart_tx_done_tick : transmitter side
//   grant_id : current/last owner, arb_busy : not IDLE, timeout_err : watchdog pulse
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned DBIT = DBIT_DEF,
  parameter int unsigned TO_W = TO_W_DEF,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DBIT-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   req_done,
  output logic [DBIT-1:0]   uart_din,
  output logic              uart_tx_start,
  input  logic              uart_tx_busy,
  input  logic              uart_tx_done_tick,
  output logic [IDW-1:0]    grant_id,
  output logic              arb_busy,
`ifdef UART_LOOPBACK_CHECK_EN
  input  logic              rx_done_tick,
  input  logic [DBIT-1:0]   rx_dout,
  output logic              lb_err,
`endif
  output logic              timeout_err
);

  // Last count before all-ones: timeout is taken as the counter steps onto all-ones.
  localparam logic [TO_W-1:0] WdLast = {TO_W{1'b1}} - TO_W'(1);

  arb_state_t       state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   grant_q;
  logic [DBIT-1:0]  din_q;
  logic             start_q;
  logic [NREQ-1:0]  done_q;
  logic             tmo_q;
  logic [TO_W-1:0]  wd_q;

  logic [NREQ-1:0]  win_oh;
  logic [IDW-1:0]   win_idx;
  logic             any_valid;
  logic [DBIT-1:0]  win_data;
  logic             handshake;
  logic [IDW-1:0]   next_ptr;
  logic             finish;

  rr_pick #(
    .NREQ(NREQ)
  ) u_rr_pick (
    .valid      (req_valid),
    .rr_ptr     (rr_ptr_q),
    .winner_oh  (win_oh),
    .winner_idx (win_idx),
    .any_valid  (any_valid)
  );

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_oh[i]) begin
        win_data = req_data[i*DBIT +: DBIT];
      end
    end
  end

  // rst in the term keeps req_ready low while reset is held (state already reads IDLE).
  assign handshake = rst && (state_q == IDLE) && !uart_tx_busy && any_valid;
  assign req_ready = handshake ? win_oh : '0;
  assign next_ptr  = (32'(grant_q) == NREQ - 1) ? '0 : grant_q + IDW'(1);

`ifdef UART_LOOPBACK_CHECK_EN
  logic tx_seen_q;
  logic rx_seen_q;
  logic lb_err_q;
  assign finish = (uart_tx_done_tick || tx_seen_q) && (rx_done_tick || rx_seen_q);
  assign lb_err = lb_err_q;
`else
  assign finish = uart_tx_done_tick;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      din_q     <= '0;
      start_q   <= 1'b0;
      done_q    <= '0;
      tmo_q     <= 1'b0;
      wd_q      <= '0;
`ifdef UART_LOOPBACK_CHECK_EN
      tx_seen_q <= 1'b0;
      rx_seen_q <= 1'b0;
      lb_err_q  <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      done_q  <= '0;
      tmo_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (handshake) begin
            din_q   <= win_data;
            grant_q <= win_idx;
            start_q <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          wd_q      <= '0;
`ifdef UART_LOOPBACK_CHECK_EN
          tx_seen_q <= 1'b0;
          rx_seen_q <= 1'b0;
`endif
          state_q   <= WAIT_DONE;
        end
        WAIT_DONE: begin
          wd_q <= wd_q + TO_W'(1);
          // Completion is checked first so a done tick beats a same-cycle timeout.
          if (finish) begin
            done_q[grant_q] <= 1'b1;
            rr_ptr_q        <= next_ptr;
            state_q         <= IDLE;
          end else if (wd_q == WdLast) begin
            tmo_q    <= 1'b1;
            rr_ptr_q <= next_ptr;
            state_q  <= IDLE;
          end
`ifdef UART_LOOPBACK_CHECK_EN
          else begin
            if (uart_tx_done_tick) tx_seen_q <= 1'b1;
            if (rx_done_tick)      rx_seen_q <= 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
`ifdef UART_LOOPBACK_CHECK_EN
      if (rx_done_tick && (state_q != IDLE) && (rx_dout != din_q)) begin
        lb_err_q <= 1'b1;
      end
`endif
    end
  end

  assign uart_din      = din_q;
  assign uart_tx_start = start_q;
  assign req_done      = done_q;
  assign timeout_err   = tmo_q;
  assign grant_id      = grant_q;
  assign arb_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed bench for uart_tx_arb (NREQ=4, DBIT=8, TO_W=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1-3 units later.
module tb_uart_tx_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  req_done;
  logic [7:0]  uart_din;
  logic        uart_tx_start;
  logic        uart_tx_busy;
  logic        uart_tx_done_tick;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic        timeout_err;
`ifdef UART_LOOPBACK_CHECK_EN
  logic        rx_done_tick;
  logic [7:0]  rx_dout;
  logic        lb_err;
  logic        lb_corrupt;
  // Transmitter looped back to receiver; lb_corrupt flips the echoed byte.
  assign rx_done_tick = uart_tx_done_tick;
  assign rx_dout      = lb_corrupt ? (uart_din + 8'd1) : uart_din;
`endif

  int checks;
  int errors;

  uart_tx_arb #(
    .NREQ(4),
    .DBIT(8),
    .TO_W(4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_data          (req_data),
    .req_ready         (req_ready),
    .req_done          (req_done),
    .uart_din          (uart_din),
    .uart_tx_start     (uart_tx_start),
    .uart_tx_busy      (uart_tx_busy),
    .uart_tx_done_tick (uart_tx_done_tick),
    .grant_id          (grant_id),
    .arb_busy          (arb_busy),
`ifdef UART_LOOPBACK_CHECK_EN
    .rx_done_tick      (rx_done_tick),
    .rx_dout           (rx_dout),
    .lb_err            (lb_err),
`endif
    .timeout_err       (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, required finish before 100000");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] valid;
    logic       busy;
    logic       tick;
    logic [3:0] e_ready;
    logic [3:0] e_done;
    logic       e_start;
    logic       e_abusy;
    logic [1:0] e_grant;
    logic [7:0] e_din;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic [3:0] v, logic b, logic t, logic [3:0] r, logic [3:0] d,
                              logic s, logic ab, logic [1:0] g, logic [7:0] din);
    vec_t x;
    x.valid = v; x.busy = b; x.tick = t; x.e_ready = r; x.e_done = d;
    x.e_start = s; x.e_abusy = ab; x.e_grant = g; x.e_din = din;
    return x;
  endfunction

  // {ready, done, start, arb_busy, timeout_err, grant_id, uart_din}
  function automatic logic [20:0] outs();
    return {req_ready, req_done, uart_tx_start, arb_busy, timeout_err, grant_id, uart_din};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic       quiet_bad;
  logic [1:0] e;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    req_valid = '0;
    req_data = '0;
    uart_tx_busy = 1'b0;
    uart_tx_done_tick = 1'b0;
`ifdef UART_LOOPBACK_CHECK_EN
    lb_corrupt = 1'b0;
`endif

    vecs[0]  = mk(4'b0001, 0, 0, 4'b0001, 4'b0000, 0, 0, 2'd0, 8'h00);
    vecs[1]  = mk(4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 1, 2'd0, 8'hA5);
    vecs[2]  = mk(4'b0000, 1, 0, 4'b0000, 4'b0000, 0, 1, 2'd0, 8'hA5);
    vecs[3]  = mk(4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 1, 2'd0, 8'hA5);
    vecs[4]  = mk(4'b0010, 1, 0, 4'b0000, 4'b0001, 0, 0, 2'd0, 8'hA5);
    vecs[5]  = mk(4'b0010, 1, 0, 4'b0000, 4'b0000, 0, 0, 2'd0, 8'hA5);
    vecs[6]  = mk(4'b0010, 0, 0, 4'b0010, 4'b0000, 0, 0, 2'd0, 8'hA5);
    vecs[7]  = mk(4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 1, 2'd1, 8'h3C);
    vecs[8]  = mk(4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 1, 2'd1, 8'h3C);
    vecs[9]  = mk(4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 1, 2'd1, 8'h3C);
    vecs[10] = mk(4'b0000, 0, 0, 4'b0000, 4'b0010, 0, 0, 2'd1, 8'h3C);
    vecs[11] = mk(4'b0011, 0, 0, 4'b0001, 4'b0000, 0, 0, 2'd1, 8'h3C);
    vecs[12] = mk(4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 1, 2'd0, 8'hA5);
    vecs[13] = mk(4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 1, 2'd0, 8'hA5);
    vecs[14] = mk(4'b0011, 0, 0, 4'b0010, 4'b0001, 0, 0, 2'd0, 8'hA5);
    vecs[15] = mk(4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 1, 2'd1, 8'h3C);
    vecs[16] = mk(4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 1, 2'd1, 8'h3C);
    vecs[17] = mk(4'b0000, 0, 0, 4'b0000, 4'b0010, 0, 0, 2'd1, 8'h3C);

    // Reset state, with a valid request that must not see ready.
    step();
    req_valid = 4'b0001;
    #1;
    chk("reset_state", 32'(outs()), 32'h0);
    req_valid = '0;
    rst = 1'b1;
    step();

    // Single request, busy hold-off, rotation and wrap from the round-robin pointer.
    req_data = 32'h0000_3CA5;
    for (int i = 0; i < 18; i++) begin
      req_valid = vecs[i].valid;
      uart_tx_busy = vecs[i].busy;
      uart_tx_done_tick = vecs[i].tick;
      #1;
      chk($sformatf("vec%0d", i), 32'(outs()),
          32'({vecs[i].e_ready, vecs[i].e_done, vecs[i].e_start, vecs[i].e_abusy, 1'b0,
               vecs[i].e_grant, vecs[i].e_din}));
      step();
    end
    uart_tx_busy = 1'b0;
    uart_tx_done_tick = 1'b0;

    // Watchdog: pointer is 2, done tick withheld.
    req_data = 32'h4433_2211;
    req_valid = 4'b0100;
    #1;
    chk("to_grant", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    #1;
    chk("to_start", 32'({uart_tx_start, grant_id, uart_din}), 32'({1'b1, 2'd2, 8'h33}));
    quiet_bad = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (timeout_err || (req_done != 4'b0) || uart_tx_start || !arb_busy) quiet_bad = 1'b1;
    end
    chk("to_quiet", 32'(quiet_bad), 32'h0);
    step();
    req_valid = 4'b1100;
    #1;
    chk("to_pulse", 32'(timeout_err), 32'h1);
    chk("to_nodone", 32'(req_done), 32'h0);
    chk("to_next_grant", 32'(req_ready), 32'b1000);
    step();
    req_valid = '0;
    #1;
    chk("to_pulse_end", 32'(timeout_err), 32'h0);
    chk("to_start3", 32'({uart_tx_start, grant_id, uart_din}), 32'({1'b1, 2'd3, 8'h44}));
    step();
    uart_tx_done_tick = 1'b1;
    step();
    uart_tx_done_tick = 1'b0;
    #1;
    chk("to_done3", 32'(req_done), 32'b1000);

    // All four valid continuously: grants 0,1,2,3,0, one start per done tick.
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      e = 2'(n % 4);
      #1;
      chk($sformatf("rot%0d_ready", n), 32'(req_ready), 32'(4'b0001 << e));
      step();
      #1;
      chk($sformatf("rot%0d_start", n), 32'({uart_tx_start, grant_id, uart_din}),
          32'({1'b1, e, 8'(8'h11 * (32'(e) + 1))}));
      step();
      uart_tx_done_tick = 1'b1;
      #1;
      chk($sformatf("rot%0d_once", n), 32'({uart_tx_start, req_ready}), 32'h0);
      step();
      uart_tx_done_tick = 1'b0;
      #1;
      chk($sformatf("rot%0d_done", n), 32'(req_done), 32'(4'b0001 << e));
    end
    req_valid = '0;

    // Reset in WAIT_DONE: pointer is 1 before reset.
    req_valid = 4'b0010;
    #1;
    chk("rst_pre_grant", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    step();
    req_valid = 4'b0010;
    rst = 1'b0;
    #1;
    chk("rst_async", 32'(outs()), 32'h0);
    step();
    step();
    req_valid = '0;
    rst = 1'b1;
    uart_tx_done_tick = 1'b1;
    #1;
    chk("rst_no_done0", 32'({req_done, timeout_err}), 32'h0);
    step();
    uart_tx_done_tick = 1'b0;
    #1;
    chk("rst_no_done1", 32'({req_done, timeout_err, arb_busy}), 32'h0);
    req_valid = 4'b0011;
    #1;
    chk("rst_grant0", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    #1;
    chk("rst_start0", 32'({uart_tx_start, grant_id, uart_din}), 32'({1'b1, 2'd0, 8'h11}));
    step();
    uart_tx_done_tick = 1'b1;
    step();
    uart_tx_done_tick = 1'b0;
    #1;
    chk("rst_done0", 32'(req_done), 32'b0001);

`ifdef UART_LOOPBACK_CHECK_EN
    // Pointer is 1; only requester 0 valid, byte 5A.
    req_data = 32'h0000_005A;
    for (int p = 0; p < 2; p++) begin
      lb_corrupt = (p == 1);
      req_valid = 4'b0001;
      step();
      req_valid = '0;
      step();
      uart_tx_done_tick = 1'b1;
      step();
      uart_tx_done_tick = 1'b0;
      #1;
      chk($sformatf("lb_err%0d", p), 32'({req_done, lb_err}), 32'({4'b0001, p == 1}));
      step();
    end
    lb_corrupt = 1'b0;
    step();
    step();
    chk("lb_err_sticky", 32'(lb_err), 32'h1);
    rst = 1'b0;
    #1;
    chk("lb_err_reset", 32'(lb_err), 32'h0);
    rst = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter and sequencer that shares one uart transmitter among NREQ byte requesters.
- Accepts a byte per valid/ready handshake, drives uart_din/uart_tx_start, waits for uart_tx_done_tick, then reports completion to the owning requester.
- Sits between APB-side requesters (register/bridge logic) and the uart top.
- Includes a watchdog so a stalled transmitter never hangs the arbiter.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DBIT, 8, data bits per character (matches uart).
- TO_W, 20, width of watchdog counter; timeout fires after 2**TO_W-1 cycles in WAIT_DONE.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  NREQ*DBIT  packed bytes; requester i occupies bits [i*DBIT +: DBIT].
- req_ready  out  NREQ  per-requester accept; a transfer occurs on valid&&ready.
- req_done  out  NREQ  one-cycle pulse to the owner when its byte has finished.
- uart_din  out  DBIT  byte to uart transmitter.
- uart_tx_start  out  1  one-cycle start strobe.
- uart_tx_busy  in  1  transmitter busy.
- uart_tx_done_tick  in  1  transmitter done strobe.
- grant_id  out  $clog2(NREQ)  current/last owner index.
- arb_busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle pulse when the watchdog expires.

Behaviour:
- Reset values (rst low, asynchronous):
  - state=IDLE, rr_ptr=0, grant_id=0, uart_din=0.
  - uart_tx_start=0, req_done=0, timeout_err=0, watchdog=0.
  - req_ready=0 while in reset.
- FSM states: IDLE, START, WAIT_DONE.
- IDLE:
  - winner = first i with req_valid[i], scanning from rr_ptr upward modulo NREQ.
  - req_ready is combinational: req_ready[i] = (state==IDLE) && !uart_tx_busy && any valid && (i==winner). At most one bit is ever set.
  - On handshake: register uart_din <= req_data[winner], grant_id <= winner, then go to START.
  - If no requester is valid, or uart_tx_busy is high, stay in IDLE with req_ready=0.
- START:
  - uart_tx_start=1 for exactly this one cycle. Latency: handshake cycle N, start strobe cycle N+1.
  - watchdog cleared; go to WAIT_DONE.
- WAIT_DONE:
  - watchdog increments each cycle.
  - On uart_tx_done_tick: req_done[grant_id] pulses the next cycle (registered), rr_ptr <= grant_id+1 (wraps to 0 at NREQ), go to IDLE.
  - If the watchdog reaches all-ones before the done tick: timeout_err pulses the next cycle, no req_done is issued, rr_ptr advances as on done, go to IDLE.
  - Done tick and timeout in the same cycle: the done tick wins.
- uart_din holds its value from the handshake until the next handshake.
- Next handshake is possible at the earliest in the cycle after leaving WAIT_DONE. Back-to-back requests from different requesters are served in strict rotation.
- A requester deasserting req_valid in IDLE before ready is legal; the byte is not taken. Data must be stable while valid and not yet accepted.
- Reset mid-operation: the in-flight byte is dropped, no req_done or timeout_err is issued, and the state returns to IDLE asynchronously.

Optional Feature:
- Macro: UART_LOOPBACK_CHECK_EN.
- When defined, the block adds these ports:
  - rx_done_tick (in, 1).
  - rx_dout (in, DBIT).
  - lb_err (out, 1, sticky, cleared only by reset).
- WAIT_DONE additionally waits for rx_done_tick and records it. IDLE is entered only after both tx and rx done ticks have been seen, in either order and not necessarily in the same cycle.
- lb_err sets if rx_dout != uart_din on rx_done_tick.
- When the macro is not defined, those ports do not exist and the behaviour is as above.

Decomposition:
- Package uart_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, START, WAIT_DONE} arb_state_t.
  - default constants NREQ_DEF=4, DBIT_DEF=8, TO_W_DEF=20.
- One sub-module, rr_pick: purely combinational. Inputs are a valid vector and rr_ptr; outputs are a one-hot winner and a winner index.

Test Plan:
- Single request: req_valid=0001, req_data[0]=8'hA5 → req_ready[0] in the same cycle; uart_tx_start one cycle later with uart_din=A5. After the stubbed done tick, req_done[0] pulses and rr_ptr=1.
- All four valid continuously with bytes 11, 22, 33, 44 → grants in order 0, 1, 2, 3, 0; each byte starts exactly once per done tick.
- uart_tx_busy held high in IDLE with req_valid=0010 → req_ready stays 0. After busy drops, the handshake occurs the same cycle.
- Done tick never arrives (TO_W=4 build) → timeout_err pulses 16 cycles after START, no req_done, and the next requester is granted.
- rst low during WAIT_DONE → all outputs return to reset values immediately; no done pulse after rst rises; a new request is then granted from index 0.
- UART_LOOPBACK_CHECK_EN with tx looped to rx, byte 5A → lb_err stays 0. Force rx_dout=5B → lb_err sets and holds until reset.
